snn_inference_sequencer: RTL and testbench



---
 rtl/snn_ctrl_pkg.sv | 24 ++
 rtl/snn_inference_sequencer_sat_counter.sv | 37 +++
 rtl/snn_inference_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_snn_inference_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared types and helpers for the spiking-network inference sequencer.
package snn_ctrl_pkg;

    // Sequencer states; CLEAR..DONE make up one inference.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        DELAY,
        EVAL,
        CAPTURE,
        SCAN,
        DONE
    } state_e;

    // Index width needed to address n items (never less than one bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/snn_inference_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, or step up unless already pinned at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snn_inference_sequencer.sv
// Timestep controller for the two-layer spiking network: feeds one frame per
// timestep, strobes delay clock and enable, accumulates output spikes, then
// scans the counts for the winning class.
//
// Input handshake: a frame moves on a rising edge where in_ready and in_valid
// are both high. in_ready is high exactly while the sequencer sits in WAIT_IN
// and does not depend on in_valid; in_spikes must be stable while in_valid is
// high. An abort in that same cycle cancels the transfer.
module snn_inference_sequencer
    import snn_ctrl_pkg::*;
#(
    parameter int M1     = 8,
    parameter int N2     = 8,
    parameter int CNT_W  = 5,
    parameter int STEP_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [STEP_W-1:0]     num_steps,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [M1-1:0]         in_spikes,
    output logic                  net_reset,
    output logic                  net_enable,
    output logic                  net_delay_clk,
    output logic [M1-1:0]         net_input_spikes,
    input  logic [N2-1:0]         net_output_spikes,
    output logic [N2*CNT_W-1:0]   spike_counts,
    output logic [clog2(N2)-1:0]  winner,
    output logic                  no_spike,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int WIN_W = clog2(N2);
    localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(N2 - 1);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   num_steps_q, num_steps_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [WIN_W-1:0]    scan_idx_q, scan_idx_d;
    logic [WIN_W-1:0]    best_idx_q, best_idx_d;
    logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
    logic [WIN_W-1:0]    winner_q, winner_d;
    logic                no_spike_q, no_spike_d;
    logic [M1-1:0]       net_in_q, net_in_d;
    logic                net_reset_q, net_enable_q, net_delay_q, busy_q, done_q;

    logic [CNT_W-1:0]    cnt [N2];
    logic                cnt_clr;
    logic [N2-1:0]       cnt_inc;

    // One saturating spike counter per output neuron.
    for (genvar i = 0; i < N2; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr_i (cnt_clr),
            .inc_i (cnt_inc[i]),
            .cnt_o (cnt[i])
        );
        assign spike_counts[i*CNT_W +: CNT_W] = cnt[i];
    end

    // Next-state, datapath updates and counter controls; abort overrides all
    // activity outside IDLE so counts and results hold.
    always_comb begin
        state_d     = state_q;
        num_steps_d = num_steps_q;
        step_cnt_d  = step_cnt_q;
        scan_idx_d  = scan_idx_q;
        best_idx_d  = best_idx_q;
        best_cnt_d  = best_cnt_q;
        winner_d    = winner_q;
        no_spike_d  = no_spike_q;
        net_in_d    = net_in_q;
        cnt_clr     = 1'b0;
        cnt_inc     = '0;
        if ((state_q != IDLE) && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_steps_d = num_steps;
                        step_cnt_d  = '0;
                        state_d     = CLEAR;
                    end
                end
                CLEAR: begin
                    cnt_clr    = 1'b1;
                    net_in_d   = '0;
                    scan_idx_d = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
                    state_d    = (num_steps_q == '0) ? SCAN : WAIT_IN;
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        net_in_d = in_spikes;
                        state_d  = DELAY;
                    end
                end
                DELAY:   state_d = EVAL;
                EVAL:    state_d = CAPTURE;
                CAPTURE: begin
                    cnt_inc    = net_output_spikes;
                    step_cnt_d = step_cnt_q + 1'b1;
                    state_d    = (step_cnt_q + 1'b1 == num_steps_q) ? SCAN : WAIT_IN;
                end
                SCAN: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (cnt[scan_idx_q] > best_cnt_q) begin
                        best_idx_d = scan_idx_q;
                        best_cnt_d = cnt[scan_idx_q];
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                    if (scan_idx_q == LAST_IDX) begin
                        // Results land together with the done pulse.
                        winner_d   = best_idx_d;
                        no_spike_d = (best_cnt_d == '0);
                        state_d    = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; pulse outputs are registered decodes of
    // the next state so each is high exactly during its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            num_steps_q  <= '0;
            step_cnt_q   <= '0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            winner_q     <= '0;
            no_spike_q   <= 1'b0;
            net_in_q     <= '0;
            net_reset_q  <= 1'b0;
            net_enable_q <= 1'b0;
            net_delay_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_steps_q  <= num_steps_d;
            step_cnt_q   <= step_cnt_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            winner_q     <= winner_d;
            no_spike_q   <= no_spike_d;
            net_in_q     <= net_in_d;
            net_reset_q  <= (state_d == CLEAR);
            net_enable_q <= (state_d == EVAL);
            net_delay_q  <= (state_d == DELAY);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    assign in_ready         = (state_q == WAIT_IN);
    assign net_reset        = net_reset_q;
    assign net_enable       = net_enable_q;
    assign net_delay_clk    = net_delay_q;
    assign net_input_spikes = net_in_q;
    assign winner           = winner_q;
    assign no_spike         = no_spike_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Bench for snn_inference_sequencer: two instances (5-bit and 4-bit counters)
// share one stimulus stream; expected results are queued at launch.
module tb_snn_inference_sequencer;
    import snn_ctrl_pkg::*;

    localparam int M1     = 8;
    localparam int N2     = 8;
    localparam int STEP_W = 5;
    localparam int CW_A   = 5;
    localparam int CW_B   = 4;
    localparam int WIN_W  = 3;
    localparam int RA_W   = N2*CW_A + WIN_W + 1;
    localparam int RB_W   = N2*CW_B + WIN_W + 1;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, abort, in_valid;
    logic [STEP_W-1:0] num_steps;
    logic [M1-1:0]     in_spikes;
    logic [N2-1:0]     net_output_spikes;

    logic a_in_ready, a_net_reset, a_net_enable, a_net_delay_clk, a_no_spike, a_busy, a_done;
    logic [M1-1:0]      a_net_input_spikes;
    logic [N2*CW_A-1:0] a_spike_counts;
    logic [WIN_W-1:0]   a_winner;
    state_e             a_state;

    logic b_in_ready, b_net_reset, b_net_enable, b_net_delay_clk, b_no_spike, b_busy, b_done;
    logic [M1-1:0]      b_net_input_spikes;
    logic [N2*CW_B-1:0] b_spike_counts;
    logic [WIN_W-1:0]   b_winner;
    state_e             b_state;

    snn_inference_sequencer #(.M1(M1), .N2(N2), .CNT_W(CW_A), .STEP_W(STEP_W)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_steps(num_steps),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_spikes(in_spikes),
        .net_reset(a_net_reset), .net_enable(a_net_enable), .net_delay_clk(a_net_delay_clk),
        .net_input_spikes(a_net_input_spikes), .net_output_spikes(net_output_spikes),
        .spike_counts(a_spike_counts), .winner(a_winner), .no_spike(a_no_spike),
        .busy(a_busy), .done(a_done), .dbg_state(a_state)
    );

    snn_inference_sequencer #(.M1(M1), .N2(N2), .CNT_W(CW_B), .STEP_W(STEP_W)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_steps(num_steps),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_spikes(in_spikes),
        .net_reset(b_net_reset), .net_enable(b_net_enable), .net_delay_clk(b_net_delay_clk),
        .net_input_spikes(b_net_input_spikes), .net_output_spikes(net_output_spikes),
        .spike_counts(b_spike_counts), .winner(b_winner), .no_spike(b_no_spike),
        .busy(b_busy), .done(b_done), .dbg_state(b_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad    = 0;

    logic [RA_W-1:0] exp_a_q[$];
    logic [RB_W-1:0] exp_b_q[$];
    logic [15:0]     exp_lat_q[$];

    logic [N2-1:0]    step_pat [32];
    logic [WIN_W-1:0] last_win_a, last_win_b;
    logic             last_ns_a, last_ns_b;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result {counts, winner, no_spike} after n steps of step_pat.
    function automatic logic [127:0] model_res(input int n, input int cw);
        int cnt[N2];
        int maxv, best, bidx;
        logic [127:0] r;
        maxv = (1 << cw) - 1;
        for (int i = 0; i < N2; i++) cnt[i] = 0;
        for (int s = 0; s < n; s++)
            for (int i = 0; i < N2; i++)
                if (step_pat[s][i] && cnt[i] < maxv) cnt[i]++;
        best = 0;
        bidx = 0;
        for (int i = 0; i < N2; i++)
            if (cnt[i] > best) begin
                best = cnt[i];
                bidx = i;
            end
        r = '0;
        for (int i = 0; i < N2; i++) r = r | (128'(cnt[i]) << (i*cw));
        r = (r << (WIN_W + 1)) | (128'(bidx) << 1) | 128'(best == 0);
        return r;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_counts_a"}, a_spike_counts, 0);
        check_eq({tag, "_counts_b"}, b_spike_counts, 0);
        check_eq({tag, "_res_a"}, {a_winner, a_no_spike}, 0);
        check_eq({tag, "_res_b"}, {b_winner, b_no_spike}, 0);
        check_eq({tag, "_ctl_a"}, {a_in_ready, a_net_reset, a_net_enable, a_net_delay_clk, a_busy, a_done}, 0);
        check_eq({tag, "_ctl_b"}, {b_in_ready, b_net_reset, b_net_enable, b_net_delay_clk, b_busy, b_done}, 0);
        check_eq({tag, "_frame_a"}, a_net_input_spikes, 0);
    endtask

    // ---------------- driver ----------------
    task automatic run_inf(input int n, input int stall_step, input int stall_len,
                           input int abort_step, input bit use_reset, input bit noisy,
                           input bit launch_abort);
        int c, acc, stall_left, en_cnt, dly_cnt, rst_cnt, lat;
        bit finished, hold, saw_done;
        logic [M1-1:0]   frame [32];
        logic [127:0]    pr;
        logic [RA_W-1:0] ea;
        logic [RB_W-1:0] eb;
        logic [15:0]     el;
        if (abort_step < 0) begin
            lat = 1 + 4*n + ((stall_step >= 0 && stall_step < n) ? stall_len : 0) + N2 + 1;
            exp_a_q.push_back(RA_W'(model_res(n, CW_A)));
            exp_b_q.push_back(RB_W'(model_res(n, CW_B)));
            exp_lat_q.push_back(16'(lat));
        end
        @(negedge clk);
        start     = 1'b1;
        abort     = launch_abort;
        num_steps = STEP_W'(n);
        in_valid  = noisy;
        in_spikes = M1'($urandom);
        c = 0; acc = 0; stall_left = stall_len;
        en_cnt = 0; dly_cnt = 0; rst_cnt = 0;
        finished = 1'b0; hold = 1'b0;
        while (!finished && c < 2000) begin
            @(negedge clk);
            c++;
            if (a_net_reset) rst_cnt++;
            if (a_net_enable) en_cnt++;
            if (a_net_delay_clk) dly_cnt++;
            if (a_net_delay_clk) begin
                if (acc > 0) check_eq("frame", a_net_input_spikes, frame[acc-1]);
                else check_eq("early_delay", a_net_delay_clk, 0);
            end
            if (a_done) begin
                start = 1'b0;
                in_valid = 1'b0;
                finished = 1'b1;
                if (abort_step >= 0) begin
                    check_eq("done_in_abort_run", a_done, 0);
                end else begin
                    el = exp_lat_q.pop_front();
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    check_eq("latency", c, el);
                    check_eq("counts_a", a_spike_counts, ea[RA_W-1:WIN_W+1]);
                    check_eq("winner_a", a_winner, ea[WIN_W:1]);
                    check_eq("no_spike_a", a_no_spike, ea[0]);
                    check_eq("done_b", b_done, 1);
                    check_eq("counts_b", b_spike_counts, eb[RB_W-1:WIN_W+1]);
                    check_eq("winner_b", b_winner, eb[WIN_W:1]);
                    check_eq("no_spike_b", b_no_spike, eb[0]);
                    check_eq("enable_pulses", en_cnt, n);
                    check_eq("delay_pulses", dly_cnt, n);
                    check_eq("reset_pulses", rst_cnt, 1);
                    check_eq("frame_hold", a_net_input_spikes, (n == 0) ? '0 : frame[n-1]);
                    last_win_a = ea[WIN_W:1]; last_ns_a = ea[0];
                    last_win_b = eb[WIN_W:1]; last_ns_b = eb[0];
                    @(negedge clk);
                    check_eq("done_one_cycle", a_done, 0);
                    check_eq("busy_after_done", a_busy, 0);
                end
            end else if (abort_step >= 0 && a_net_enable && acc == abort_step + 1) begin
                start = 1'b0;
                in_valid = 1'b0;
                finished = 1'b1;
                if (use_reset) reset = 1'b1;
                else abort = 1'b1;
                @(negedge clk);
                if (use_reset) begin
                    check_idle_zero("midrun_reset");
                    reset = 1'b0;
                    last_win_a = '0; last_ns_a = 1'b0;
                    last_win_b = '0; last_ns_b = 1'b0;
                    @(negedge clk);
                end else begin
                    abort = 1'b0;
                    pr = model_res(abort_step, CW_A);
                    check_eq("abort_counts_a", a_spike_counts, pr[RA_W-1:WIN_W+1]);
                    pr = model_res(abort_step, CW_B);
                    check_eq("abort_counts_b", b_spike_counts, pr[RB_W-1:WIN_W+1]);
                    check_eq("abort_winner_a", {a_winner, a_no_spike}, {last_win_a, last_ns_a});
                    check_eq("abort_winner_b", {b_winner, b_no_spike}, {last_win_b, last_ns_b});
                end
                check_eq("abort_busy", a_busy, 0);
                check_eq("abort_state", a_state, IDLE);
                check_eq("abort_pulses", {a_net_enable, a_net_delay_clk, a_done}, 0);
                saw_done = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    saw_done = saw_done | a_done;
                end
                check_eq("abort_no_done", saw_done, 0);
            end else begin
                if (c == 1) begin
                    abort = 1'b0;
                    num_steps = STEP_W'($urandom);
                end
                start = (c > 1 && noisy) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (a_net_enable) begin
                    net_output_spikes = (acc > 0) ? step_pat[acc-1] : '0;
                    hold = 1'b1;
                end else if (hold) begin
                    hold = 1'b0;
                end else begin
                    net_output_spikes = N2'($urandom);
                end
                if (a_in_ready) begin
                    if (acc == stall_step && stall_left > 0) begin
                        in_valid = 1'b0;
                        stall_left--;
                        check_eq("stall_no_enable", a_net_enable, 0);
                    end else begin
                        in_valid = 1'b1;
                        in_spikes = M1'($urandom);
                        if (acc < 32) frame[acc] = in_spikes;
                        acc++;
                    end
                end else begin
                    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
                    in_spikes = M1'($urandom);
                end
            end
        end
        check_eq("run_finished", finished, 1);
    endtask

    task automatic fill_const(input logic [N2-1:0] p);
        for (int s = 0; s < 32; s++) step_pat[s] = p;
    endtask

    task automatic fill_rand();
        for (int s = 0; s < 32; s++) step_pat[s] = N2'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        num_steps = '0; in_spikes = '0; net_output_spikes = '0;
        last_win_a = '0; last_win_b = '0; last_ns_a = 1'b0; last_ns_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        check_eq("reset_state", a_state, IDLE);
        reset = 1'b0;

        fill_const(8'b0000_0100);
        run_inf(3, -1, 0, -1, 1'b0, 1'b0, 1'b1);     // start and abort together: start wins
        fill_const(8'b0010_0010);
        run_inf(4, -1, 0, -1, 1'b0, 1'b0, 1'b0);     // tie between neuron 1 and 5
        fill_const(8'b1000_0001);
        run_inf(31, -1, 0, -1, 1'b0, 1'b0, 1'b0);    // saturation in both widths
        run_inf(0, -1, 0, -1, 1'b0, 1'b0, 1'b0);     // zero steps
        fill_rand();
        run_inf(3, 1, 5, -1, 1'b0, 1'b0, 1'b0);      // stall in step 2
        fill_rand();
        run_inf(4, -1, 0, 1, 1'b0, 1'b0, 1'b0);      // abort in EVAL of step 2
        fill_rand();
        run_inf(2, -1, 0, -1, 1'b0, 1'b0, 1'b0);     // restart after abort
        fill_rand();
        run_inf(4, -1, 0, 1, 1'b1, 1'b0, 1'b0);      // reset in EVAL of step 2
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_rand();
            run_inf(n, $urandom_range(0, n - 1), $urandom_range(0, 4), -1, 1'b0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
